// File: rtl/seg7_scan_reader.sv
// Passive 7-seg scan monitor: decodes settled {anode, segment} pairs back to per-digit BCD values.
// Capture lands STABLE_CYCLES-1 edges after a pair is first sampled; no backpressure (observe-only).
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   anod_i,
    output logic [4*NUM_DIGITS-1:0] cifre_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    upd_o,
    output logic [IDX_W-1:0]        upd_idx_o,
    output logic                    frame_o
);
    localparam int SMP_W = NUM_DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SMP_W-1:0]        sample_q, sample_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    capt_q, capt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] cifre_q, cifre_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    upd_q, upd_d;
    logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
    logic                    frame_q, frame_d;

    logic                  same;
    logic                  one_low;
    logic                  fire;
    logic [NUM_DIGITS-1:0] act;
    logic [NUM_DIGITS-1:0] mask_set;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            dec_val;
    logic                  dec_err;

    // Segment decode of the live pattern; at capture it equals the held sample.
    always_comb begin
        dec_val = 4'hF;
        dec_err = 1'b1;
        case (seg_i)
            7'b1000000: begin dec_val = 4'd0; dec_err = 1'b0; end
            7'b1111001: begin dec_val = 4'd1; dec_err = 1'b0; end
            7'b0100100: begin dec_val = 4'd2; dec_err = 1'b0; end
            7'b0110000: begin dec_val = 4'd3; dec_err = 1'b0; end
            7'b0011001: begin dec_val = 4'd4; dec_err = 1'b0; end
            7'b0010010: begin dec_val = 4'd5; dec_err = 1'b0; end
            7'b0000010: begin dec_val = 4'd6; dec_err = 1'b0; end
            7'b1111000: begin dec_val = 4'd7; dec_err = 1'b0; end
            7'b0000000: begin dec_val = 4'd8; dec_err = 1'b0; end
            7'b0010000: begin dec_val = 4'd9; dec_err = 1'b0; end
            7'b0000110: begin dec_val = 4'hE; dec_err = 1'b1; end
            default:    begin dec_val = 4'hF; dec_err = 1'b1; end
        endcase
    end

    always_comb begin
        act = ~anod_i;
        one_low = (act != '0) && ((act & (act - 1'b1)) == '0);
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act[i]) idx = IDX_W'(i);
        end
    end

    always_comb begin
        sample_d  = {anod_i, seg_i};
        same      = (sample_d == sample_q);
        cnt_d     = same ? ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1) : CNT_W'(1);
        capt_d    = same ? capt_q : 1'b0;
        fire      = (cnt_d == CNT_MAX) && !capt_d && one_low;
        mask_d    = mask_q;
        mask_set  = mask_q;
        cifre_d   = cifre_q;
        err_d     = err_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        frame_d   = 1'b0;
        if (fire) begin
            capt_d              = 1'b1;
            cifre_d[4*idx +: 4] = dec_val;
            err_d[idx]          = dec_err;
            upd_d               = 1'b1;
            upd_idx_d           = idx;
            mask_set[idx]       = 1'b1;
            // The completing capture opens a fresh, empty frame.
            if (&mask_set) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d  = mask_set;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q  <= '0;
            cnt_q     <= '0;
            capt_q    <= 1'b0;
            mask_q    <= '0;
            cifre_q   <= '1;
            err_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            capt_q    <= capt_d;
            mask_q    <= mask_d;
            cifre_q   <= cifre_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            frame_q   <= frame_d;
        end
    end

    assign cifre_o   = cifre_q;
    assign err_o     = err_q;
    assign upd_o     = upd_q;
    assign upd_idx_o = upd_idx_q;
    assign frame_o   = frame_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;
    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  anod;
    logic [15:0] cifre;
    logic [3:0]  err;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        frame;

    int checks = 0;
    int errors = 0;
    int n_upd, first_cyc, n_frame, n_frame_upd;
    logic [1:0] last_idx;

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk_i(clk), .rst_i(rst), .seg_i(seg), .anod_i(anod),
        .cifre_o(cifre), .err_o(err), .upd_o(upd), .upd_idx_o(upd_idx), .frame_o(frame)
    );

    always #5 clk = ~clk;

    // Applies a pair at a falling edge and records strobe activity over n cycles.
    // Cycle i (1-based) reflects the i-th rising edge that sampled the pair.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        anod = a; seg = s;
        n_upd = 0; first_cyc = 0; n_frame = 0; n_frame_upd = 0; last_idx = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (upd) begin
                n_upd++;
                if (first_cyc == 0) first_cyc = i;
                last_idx = upd_idx;
            end
            if (frame) begin
                n_frame++;
                if (upd) n_frame_upd++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; anod = 4'b1111; seg = 7'b1111111;
        repeat (2) @(negedge clk);
        checks++; if (cifre !== 16'hFFFF) begin errors++; $display("FAIL rst_cifre got %h want ffff", cifre); end
        checks++; if (err !== 4'h0) begin errors++; $display("FAIL rst_err got %b want 0000", err); end
        checks++; if ({upd, upd_idx, frame} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b want 0000", {upd, upd_idx, frame}); end
        rst = 1'b0;
    endtask

    task automatic test_single_capture();
        hold(4'b1110, 7'b0100100, 10);
        checks++; if (n_upd !== 1) begin errors++; $display("FAIL single_npulse got %0d want 1", n_upd); end
        checks++; if (first_cyc !== SC) begin errors++; $display("FAIL single_latency got %0d want %0d", first_cyc, SC); end
        checks++; if (last_idx !== 2'd0) begin errors++; $display("FAIL single_idx got %0d want 0", last_idx); end
        checks++; if (cifre[3:0] !== 4'd2 || err[0] !== 1'b0) begin errors++; $display("FAIL single_val got %h/%b want 2/0", cifre[3:0], err[0]); end
    endtask

    task automatic test_glitch();
        hold(4'b1101, 7'b0110000, 3);
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL glitch_short got %0d want 0", n_upd); end
        hold(4'b1101, 7'b0010010, 6);
        checks++; if (n_upd !== 1 || first_cyc !== SC) begin errors++; $display("FAIL glitch_cap got %0d@%0d want 1@%0d", n_upd, first_cyc, SC); end
        checks++; if (last_idx !== 2'd1 || cifre[7:4] !== 4'd5) begin errors++; $display("FAIL glitch_val got idx %0d val %h want 1/5", last_idx, cifre[7:4]); end
    endtask

    task automatic test_full_scan();
        logic [6:0] pats [4];
        logic [3:0] an;
        pats[0] = 7'b1111001; pats[1] = 7'b0010000; pats[2] = 7'b0000000; pats[3] = 7'b1000000;
        for (int d = 0; d < ND; d++) begin
            hold(4'b1111, 7'b1111111, 2);
            checks++; if (n_upd !== 0) begin errors++; $display("FAIL scan_blank%0d got %0d want 0", d, n_upd); end
            an = 4'b1111; an[d] = 1'b0;
            hold(an, pats[d], 6);
            checks++; if (n_upd !== 1 || last_idx !== 2'(d)) begin errors++; $display("FAIL scan_d%0d got %0d pulses idx %0d want 1 idx %0d", d, n_upd, last_idx, d); end
            checks++;
            if (n_frame !== ((d == 3) ? 1 : 0) || n_frame_upd !== n_frame) begin
                errors++; $display("FAIL scan_frame%0d got %0d (with upd %0d) want %0d", d, n_frame, n_frame_upd, (d == 3) ? 1 : 0);
            end
        end
        checks++; if (cifre !== 16'h0891 || err !== 4'h0) begin errors++; $display("FAIL scan_final got %h/%b want 0891/0000", cifre, err); end
    endtask

    task automatic test_invalid();
        hold(4'b1011, 7'b0000110, 6);
        checks++; if (n_upd !== 1 || cifre[11:8] !== 4'hE || err[2] !== 1'b1) begin errors++; $display("FAIL inv_E got %0d %h %b want 1 e 1", n_upd, cifre[11:8], err[2]); end
        hold(4'b1011, 7'b1010101, 6);
        checks++; if (n_upd !== 1 || cifre[11:8] !== 4'hF || err[2] !== 1'b1) begin errors++; $display("FAIL inv_F got %0d %h %b want 1 f 1", n_upd, cifre[11:8], err[2]); end
        hold(4'b1011, 7'b1111000, 6);
        checks++; if (n_upd !== 1 || cifre[11:8] !== 4'd7 || err[2] !== 1'b0) begin errors++; $display("FAIL inv_7 got %0d %h %b want 1 7 0", n_upd, cifre[11:8], err[2]); end
        checks++; if (n_frame !== 0) begin errors++; $display("FAIL inv_frame got %0d want 0", n_frame); end
        checks++; if (cifre !== 16'h0791 || err !== 4'h0) begin errors++; $display("FAIL inv_final got %h/%b want 0791/0000", cifre, err); end
    endtask

    task automatic test_overlap();
        hold(4'b1100, 7'b1000000, 10);
        checks++; if (n_upd !== 0 || n_frame !== 0) begin errors++; $display("FAIL overlap_pulse got %0d/%0d want 0/0", n_upd, n_frame); end
        checks++; if (cifre !== 16'h0791 || err !== 4'h0) begin errors++; $display("FAIL overlap_hold got %h/%b want 0791/0000", cifre, err); end
        hold(4'b1111, 7'b1111111, 10);
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL blank_pulse got %0d want 0", n_upd); end
    endtask

    task automatic test_reset_mid();
        hold(4'b1110, 7'b1000000, 2);
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL rmid_pre got %0d want 0", n_upd); end
        rst = 1'b1;
        #1;
        checks++; if (cifre !== 16'hFFFF || err !== 4'h0 || upd !== 1'b0 || frame !== 1'b0) begin errors++; $display("FAIL rmid_async got %h/%b/%b/%b want ffff/0000/0/0", cifre, err, upd, frame); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(4'b1110, 7'b1000000, 6);
        checks++; if (n_upd !== 1 || first_cyc !== SC) begin errors++; $display("FAIL rmid_cap got %0d@%0d want 1@%0d", n_upd, first_cyc, SC); end
        checks++; if (cifre !== 16'hFFF0) begin errors++; $display("FAIL rmid_val got %h want fff0", cifre); end
        hold(4'b1111, 7'b1111111, 2);
        hold(4'b1101, 7'b1111001, 6);
        checks++; if (n_upd !== 1 || n_frame !== 0) begin errors++; $display("FAIL rmid_d1 got %0d/%0d want 1/0", n_upd, n_frame); end
        hold(4'b0111, 7'b0011001, 6);
        checks++; if (n_upd !== 1 || n_frame !== 0) begin errors++; $display("FAIL rmid_d3 got %0d/%0d want 1/0", n_upd, n_frame); end
        hold(4'b1011, 7'b0100100, 6);
        checks++; if (n_upd !== 1 || n_frame_upd !== 1 || n_frame !== 1) begin errors++; $display("FAIL rmid_d2 got %0d/%0d want 1/1", n_upd, n_frame); end
        checks++; if (cifre !== 16'h4210) begin errors++; $display("FAIL rmid_final got %h want 4210", cifre); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_glitch();
        test_full_scan();
        test_invalid();
        test_overlap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Passive monitor on the multiplexed 7-segment display bus driven by the team's BCD-to-7-segment decoder plus its digit scanner.
- Watches the active-low segment lines and the active-low anode lines, and filters scan-transition glitches.
- Decodes each settled segment pattern back to its BCD value and holds one 4-bit value per display digit.
- Used for self-check and loopback of the display path, and to expose displayed values to test logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), >=1.
- STABLE_CYCLES, 4, consecutive identical samples required before capture, >=2.
- IDX_W (localparam), max(1, clog2(NUM_DIGITS)), digit index width.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- seg_i  input  7  segment lines, active-low, bit0=a … bit6=g.
- anod_i  input  NUM_DIGITS  digit enables, active-low, bit n = digit n.
- cifre_o  output  4*NUM_DIGITS  captured values, digit n at [4n+3:4n].
- err_o  output  NUM_DIGITS  bit n = last capture of digit n was not a decimal digit.
- upd_o  output  1  one-cycle strobe, a capture occurred.
- upd_idx_o  output  IDX_W  index of captured digit, valid when upd_o=1.
- frame_o  output  1  one-cycle strobe, every digit captured since previous frame_o.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: cifre_o all 4'hF, err_o 0, upd_o 0, upd_idx_o 0, frame_o 0.
- Reset also clears the internal sample register, stability counter, "captured" flag and frame mask.
- Every rising edge samples the pair {anod_i, seg_i}.
- If the sample equals the previous sample, the stability counter increments, saturating at STABLE_CYCLES. Otherwise the counter loads 1 and the captured flag clears.
- Capture fires on the edge where the counter reaches STABLE_CYCLES (STABLE_CYCLES identical consecutive samples), the captured flag is clear, and anod_i has exactly one bit low.
- After capture the captured flag is set, so a held input yields exactly one capture.
- Anode with zero bits low (blank interval) or more than one bit low (overlap): no capture. The counter still runs, and only a change restarts qualification.
- Latency: pair first sampled at edge k and held → cifre_o/err_o/upd_o updated after edge k+STABLE_CYCLES-1.
- Pattern decode (seg_i, active-low) → value/err:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, all err 0.
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, all err 0.
  - 0000110 ("E") → 4'hE, err 1.
  - Any other pattern, including blank 1111111 → 4'hF, err 1.
- On capture of digit n:
  - cifre_o[4n+3:4n] and err_o[n] are written; other digits are unchanged.
  - upd_o=1 and upd_idx_o=n for exactly one cycle.
  - Mask bit n is set.
- frame_o pulses in the same cycle as the upd_o whose capture completes the mask (all NUM_DIGITS bits). The mask then clears, with that capture not counted toward the next frame.
- Recapturing an already-masked digit updates its value but does not advance the frame.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-qualification aborts it. After release, a full STABLE_CYCLES run is required before the next capture.

Test Plan:
- Reset, then anod_i=1110, seg_i=0100100 held 10 cycles (STABLE_CYCLES=4) → one upd_o pulse after the 4th sampling edge, upd_idx_o=0, cifre_o[3:0]=2, err_o[0]=0, no further pulses.
- Glitch: anod_i=1101, seg_i=0110000 for 3 cycles, then 0010010 held → no capture of 3; digit 1 captured as 5 after 4 stable edges.
- Full scan: digits 0..3 show 1,9,8,0, each held 6 cycles with 2 blank cycles (anod_i=1111) between → four upd_o pulses, cifre_o=16'h0891, frame_o coincident with the digit-3 upd_o only.
- Invalid patterns: 0000110 on digit 2 → cifre_o[11:8]=E, err_o[2]=1. Then 1010101 → F, err_o[2]=1. Then 1111000 → 7, err_o[2]=0.
- Overlap: anod_i=1100 held 10 cycles with any seg_i → no upd_o, outputs unchanged.
- Reset mid-operation: assert rst_i after 2 stable cycles of digit 0 → outputs return to reset values immediately. Release and hold the same pair → capture exactly STABLE_CYCLES edges later, and the frame mask restarts empty.
